// File: rtl/range_pkg.sv
// Shared types and defaults for the range finder burst sequencer.
// Optional statistics are enabled by defining RANGE_SEQ_STATS_EN.
package range_pkg;

    typedef enum logic [1:0] {FILL, DROP, PLAY, GAP} seq_state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH = 16;

endpackage

// File: rtl/range_frame_buffer.sv
// DEPTH x WIDTH frame store: one synchronous write port, one combinational read port.
// Storage is intentionally unreset.
module range_frame_buffer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/range_burst_sequencer.sv
// Buffers one frame from a valid/ready/last stream and replays it as a gap-free go..finish burst,
// followed by one mandatory idle cycle. Define RANGE_SEQ_STATS_EN to add frame counters.
module range_burst_sequencer
    import range_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             go,
    output logic             finish,
    output logic             busy,
    output logic             overflow
`ifdef RANGE_SEQ_STATS_EN
    ,
    output logic [15:0]      frames_sent,
    output logic [15:0]      frames_dropped
`endif
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    seq_state_t        state;
    logic [CW-1:0]     count;
    logic [CW-1:0]     len;
    logic [CW-1:0]     k;
    logic              beat;
    logic              we;
    logic [AW-1:0]     waddr;
    logic [AW-1:0]     raddr;
    logic [WIDTH-1:0]  rdata;

    range_frame_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_buf (
        .clock (clock),
        .we    (we),
        .waddr (waddr),
        .wdata (in_data),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_comb begin
        in_ready = !reset && (state == FILL || state == DROP);
        busy     = (state == PLAY) || (state == GAP);
        beat     = in_valid && in_ready;
        we       = beat && (state == FILL) && (count != DEPTH_C);
        waddr    = AW'(count);
        // Read index 0 outside PLAY so the first sample is ready when the last beat lands.
        raddr    = '0;
        if (state == PLAY && len != ONE_C && k < len) begin
            raddr = AW'(k);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= FILL;
            count    <= '0;
            len      <= '0;
            k        <= '0;
            data_out <= '0;
            go       <= 1'b0;
            finish   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            overflow <= 1'b0;
            case (state)
                FILL: begin
                    if (beat) begin
                        if (count == DEPTH_C) begin
                            overflow <= 1'b1;
                            count    <= '0;
                            state    <= in_last ? FILL : DROP;
                        end else begin
                            count <= count + ONE_C;
                            if (in_last) begin
                                state  <= PLAY;
                                len    <= count + ONE_C;
                                k      <= ONE_C;
                                go     <= 1'b1;
                                finish <= 1'b0;
                                // A one-sample frame is written on this same edge: bypass the store.
                                data_out <= (count == '0) ? in_data : rdata;
                            end
                        end
                    end
                end
                DROP: begin
                    if (beat && in_last) begin
                        state <= FILL;
                    end
                end
                PLAY: begin
                    go <= 1'b0;
                    if (finish) begin
                        finish <= 1'b0;
                        state  <= GAP;
                    end else begin
                        // Single-sample frames repeat mem[0] so go and finish land on separate cycles.
                        data_out <= rdata;
                        finish   <= (len == ONE_C) || (k == len - ONE_C);
                        k        <= k + ONE_C;
                    end
                end
                GAP: begin
                    state <= FILL;
                    count <= '0;
                end
                default: state <= FILL;
            endcase
        end
    end

`ifdef RANGE_SEQ_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frames_sent    <= '0;
            frames_dropped <= '0;
        end else begin
            if (state == PLAY && finish) begin
                frames_sent <= frames_sent + 16'd1;
            end
            if (state == FILL && beat && count == DEPTH_C) begin
                frames_dropped <= frames_dropped + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/range_burst_sequencer.md
# range_burst_sequencer

Upstream feeder for the range finder. It accepts samples over a valid/ready stream delimited by a last flag and buffers one whole frame. It then replays the frame as the contiguous burst the range finder requires: go on the first sample, one sample every cycle, finish on the last sample, no gaps. It also enforces the mandatory idle cycle the range finder needs between bursts, and drops frames too long to buffer.

## Interface
- WIDTH, 8: sample width in bits.
- DEPTH, 16: frame buffer entries; legal range DEPTH ≥ 2.
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_data  in  WIDTH  sample.
- in_valid  in  1  sample present.
- in_last  in  1  sample is the final one of its frame.
- in_ready  out  1  block accepts a sample this cycle.
- data_out  out  WIDTH  to range finder data_in.
- go  out  1  to range finder go.
- finish  out  1  to range finder finish.
- busy  out  1  high during the PLAY and GAP states.
- overflow  out  1  one-cycle pulse when a frame is dropped.

## Operation
- Reset values: data_out=0, go=0, finish=0, busy=0, overflow=0, state=FILL, count=0.
- in_ready=0 while reset is high.
- Beat = in_valid && in_ready.
- States:
  - FILL:
    - in_ready=1.
    - A beat with count<DEPTH writes mem[count] and increments count.
    - If that beat has in_last=1, go to PLAY with len=count+1.
    - A beat with count==DEPTH is an overflow: pulse overflow, reset count to 0, discard the beat.
    - After an overflow, stay in FILL if the beat has in_last=1, else go to DROP.
  - DROP:
    - in_ready=1; beats are discarded.
    - A beat with in_last=1 goes to FILL.
  - PLAY:
    - in_ready=0.
    - Index k advances 0..len-1, one per cycle.
    - data_out=mem[k], go=(k==0), finish=(k==len-1).
    - Special case len==1: emit two cycles. Cycle 0 is mem[0] with go=1, finish=0. Cycle 1 is mem[0] with go=0, finish=1. The range finder then reports range 0 instead of entering its error state.
    - After the finish cycle, go to GAP.
  - GAP:
    - Exactly one cycle with go=0, finish=0, data_out held, in_ready=0.
    - Then go to FILL with count=0.
- go and finish are never high in the same cycle.
- After the first cycle, go is never high while finish is pending.
- Arithmetic:
  - count and k are $clog2(DEPTH+1) bits wide.
  - No wrap-around; count saturates at DEPTH.
  - Frame length is 1..DEPTH.
- In DROP, in_data values are ignored.
- Reset asserted mid-PLAY: outputs go to 0 immediately, the partial burst is abandoned, and the state returns to FILL.

## Timing
- go, finish, data_out and overflow are registered outputs. in_ready is combinational from state.
- If the in_last beat is accepted at edge t, go=1 with mem[0] is visible in cycle t+1.
- A burst of length L (L≥2) occupies cycles t+1..t+L. GAP is at t+L+1. in_ready=1 again at t+L+2.
- A 1-sample frame gives burst cycles t+1..t+2, GAP at t+3, and FILL at t+4.
- Minimum spacing between finish and the next go is 2 cycles. This matches the range finder's DONE→START sequence.
- overflow is high in the cycle after the offending beat.

## Configuration
- RANGE_SEQ_STATS_EN defined:
  - Adds outputs frames_sent[15:0] and frames_dropped[15:0]. Both reset to 0 and wrap at 2^16.
  - frames_sent increments on each finish cycle.
  - frames_dropped increments with each overflow pulse.
- RANGE_SEQ_STATS_EN undefined: these ports and counters do not exist, and all other behaviour is identical.

## Structure
- Shared package range_pkg holds:
  - the state enum seq_state_t {FILL, DROP, PLAY, GAP};
  - the default WIDTH and DEPTH localparams.
- One sub-module, range_frame_buffer: a DEPTH×WIDTH register array with one write port (we, waddr, wdata) and one combinational read port (raddr → rdata). It has no reset on the storage.
- The controller, counters and output registers live in range_burst_sequencer.

## Test plan
- Frame 5, 9, 2, 7 (last on 7), in_valid held high:
  - in_ready drops after the 7 beat.
  - Next 4 cycles: data_out=5/9/2/7, go only on 5, finish only on 7.
  - Then one GAP cycle, then in_ready=1.
  - A connected range finder reports range=7.
- Single sample 42 with last:
  - Two cycles of data_out=42: first with go=1, then with finish=1.
  - Range finder reports range=0, error=0.
- DEPTH=4, frame of 6 samples:
  - overflow pulses once, on the 5th beat.
  - Remaining beats are accepted and discarded.
  - go never asserts.
  - The next 3-sample frame 1, 2, 3 plays normally.
- in_valid toggled 1,0,1,0 during fill of 10, 20, 30:
  - Only valid beats are stored.
  - Burst is 10/20/30 with no gaps.
- Reset asserted in the second PLAY cycle of a 4-sample frame:
  - go, finish and data_out are 0 in the same cycle.
  - After release, in_ready=1 and a new frame plays correctly.
- With RANGE_SEQ_STATS_EN: 3 good frames plus 1 overflowed frame → frames_sent=3, frames_dropped=1.
